// File: rtl/sram_uart_pkg.sv
// Shared types and widths for the SRAM-to-UART streamer.
// Pure definitions: no logic, no latency, no flow control.
package sram_uart_pkg;

  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 32;
  localparam int FRAME_LEN      = 10;
  localparam int BYTES_PER_WORD = DATA_W / 8;
  localparam int CNT_W          = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_NEXT = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; the handshake cycle is the first start-bit cycle, frame lasts FRAME_LEN*CLKS_PER_BIT.
// byte_rdy is low for the whole frame and returns the cycle after the stop bit, so held-valid bytes go back-to-back.
module uart_tx_byte
  import sram_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       core_clk,
  input  logic       arst_n,
  input  logic       byte_vld,
  input  logic [7:0] byte_dat,
  output logic       byte_rdy,
  output logic       tx
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  STOP_IDX = 4'(FRAME_LEN - 1);

  logic                 active;
  logic [15:0]          clk_cnt;
  logic [3:0]           bit_idx;
  logic [FRAME_LEN-1:0] frame;

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      frame   <= '0;
    end else if (!active) begin
      if (byte_vld) begin
        // The accept cycle already drives the start bit, so counting resumes at 1.
        active  <= 1'b1;
        frame   <= {1'b1, byte_dat, 1'b0};
        bit_idx <= '0;
        clk_cnt <= 16'd1;
      end
    end else if (clk_cnt == BIT_LAST) begin
      clk_cnt <= '0;
      frame   <= {1'b1, frame[FRAME_LEN-1:1]};
      if (bit_idx == STOP_IDX) begin
        active <= 1'b0;
      end else begin
        bit_idx <= bit_idx + 4'd1;
      end
    end else begin
      clk_cnt <= clk_cnt + 16'd1;
    end
  end

  assign byte_rdy = ~active;
  assign tx       = active ? frame[0] : ~byte_vld;

endmodule

// File: rtl/sram_uart_tx.sv
// Streams len 32-bit SRAM words out a UART, LSB byte first; per word: 1 read + RD_LAT wait + 40 bit times + 2 cycles.
// No backpressure upstream: start_i is ignored while busy, and bytes are released only when the serializer is ready.
module sram_uart_tx
  import sram_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int RD_LAT       = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              csb1_o,
  output logic [ADDR_W-1:0] addr1_o,
  input  logic [DATA_W-1:0] dout1_i,
  output logic              tx_o
);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [CNT_W-1:0]    remain;
  logic [2:0]          wait_cnt;
  logic [2:0]          byte_cnt;
  logic [DATA_W-1:0]   word_sreg;

  logic                byte_vld;
  logic                byte_rdy;
  logic [7:0]          byte_dat;
  logic                byte_hs;
  logic                wait_last;
  logic                send_done;
  logic                last_word;

  assign byte_hs   = byte_vld & byte_rdy;
  assign wait_last = (wait_cnt == 3'(RD_LAT - 1));
  // All four bytes handed over and the last stop bit finished.
  assign send_done = (byte_cnt == 3'(BYTES_PER_WORD)) && byte_rdy;
  assign last_word = (remain == CNT_W'(1));
  assign byte_dat  = word_sreg[7:0];
  assign addr1_o   = addr;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_i && (len_i != '0)) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_WAIT;
      ST_WAIT: if (wait_last) state_nxt = ST_SEND;
      ST_SEND: if (send_done) state_nxt = ST_NEXT;
      ST_NEXT: state_nxt = last_word ? ST_IDLE : ST_READ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    csb1_o   = 1'b1;
    busy_o   = 1'b1;
    byte_vld = 1'b0;
    case (state)
      ST_IDLE: busy_o   = 1'b0;
      ST_READ: csb1_o   = 1'b0;
      ST_SEND: byte_vld = (byte_cnt != 3'(BYTES_PER_WORD));
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      addr      <= '0;
      remain    <= '0;
      wait_cnt  <= '0;
      byte_cnt  <= '0;
      word_sreg <= '0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              addr   <= base_addr_i;
              remain <= len_i;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        ST_READ: wait_cnt <= '0;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_last) begin
            word_sreg <= dout1_i;
            byte_cnt  <= '0;
          end
        end
        ST_SEND: begin
          if (byte_hs) begin
            word_sreg <= word_sreg >> 8;
            byte_cnt  <= byte_cnt + 3'd1;
          end
        end
        ST_NEXT: begin
          addr   <= addr + ADDR_W'(1);
          remain <= remain - CNT_W'(1);
          if (last_word) done_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .core_clk (wb_clk_i),
    .arst_n   (wb_rst_ni),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat),
    .byte_rdy (byte_rdy),
    .tx       (tx_o)
  );

endmodule

// File: tb/tb_sram_uart_tx.sv
// Bench for sram_uart_tx: SRAM model, mid-bit UART receiver and read/byte scoreboards.
module tb_sram_uart_tx;

  localparam int C      = 4;
  localparam int RD_LAT = 2;

  logic        wb_clk_i    = 1'b0;
  logic        wb_rst_ni   = 1'b1;
  logic        start_i     = 1'b0;
  logic [7:0]  base_addr_i = 8'h00;
  logic [8:0]  len_i       = 9'h000;
  logic        busy_o, done_o, csb1_o, tx_o;
  logic [7:0]  addr1_o;
  logic [31:0] dout1_i;

  sram_uart_tx #(.CLKS_PER_BIT(C), .RD_LAT(RD_LAT)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .csb1_o      (csb1_o),
    .addr1_o     (addr1_o),
    .dout1_i     (dout1_i),
    .tx_o        (tx_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // SRAM: data is valid only in the RD_LAT-th cycle after the select, garbage otherwise.
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [RD_LAT];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i ^ 8'h5A), 8'(i + 1), 8'(~i), 8'(i)};
    mem[8'h10] = 32'h44332211;
  end
  always @(posedge wb_clk_i) begin
    rd_pipe[0] <= csb1_o ? 32'hDEADBEEF : mem[addr1_o];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign dout1_i = rd_pipe[RD_LAT-1];

  // Model state: expected read addresses and bytes, plus per-scenario logs.
  logic [7:0] exp_addr [$];
  logic [7:0] exp_byte [$];
  logic [7:0] rx_log [$];
  logic [7:0] rd_log [$];
  int         rx_starts [$];
  int         done_seen = 0;

  int         cyc = 0;
  bit         rx_busy = 0;
  int         rx_start = 0;
  int         prev_start = 0;
  int         word_frame = 0;
  logic [7:0] rx_shift = 8'h00;
  bit         prev_csb_low = 0;

  always @(negedge wb_clk_i) begin : compare
    int offs;
    int bidx;
    cyc++;
    if (!wb_rst_ni) begin
      check("rst_tx", tx_o, 1'b1);
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      rx_busy = 0;
      word_frame = 0;
      prev_csb_low = 0;
    end else begin
      if (!busy_o) begin
        check("idle_tx", tx_o, 1'b1);
        check("idle_csb", csb1_o, 1'b1);
      end
      if (prev_csb_low) check("csb_one_cycle", csb1_o, 1'b1);
      prev_csb_low = !csb1_o;
      if (!csb1_o) begin
        rd_log.push_back(addr1_o);
        check("read_tx_idle", tx_o, 1'b1);
        check("read_expected", exp_addr.size() != 0, 1'b1);
        if (exp_addr.size() != 0) check("read_addr", addr1_o, exp_addr.pop_front());
      end
      if (done_o) begin
        done_seen++;
        check("done_busy_low", busy_o, 1'b0);
      end
      if (!rx_busy) begin
        if (tx_o == 1'b0) begin
          rx_busy = 1;
          rx_start = cyc;
          rx_starts.push_back(cyc);
          if (word_frame % 4 != 0) check("frame_back_to_back", cyc - prev_start, 10 * C);
          prev_start = cyc;
        end
      end else begin
        offs = cyc - rx_start;
        if (offs % C == C / 2) begin
          bidx = offs / C;
          if (bidx == 0) begin
            check("start_bit", tx_o, 1'b0);
          end else if (bidx <= 8) begin
            rx_shift[bidx-1] = tx_o;
          end else begin
            check("stop_bit", tx_o, 1'b1);
            rx_busy = 0;
            word_frame++;
            rx_log.push_back(rx_shift);
            check("rx_expected", exp_byte.size() != 0, 1'b1);
            if (exp_byte.size() != 0) check("rx_byte", rx_shift, exp_byte.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [7:0] rx_at(input int i);
    return (rx_log.size() > i) ? rx_log[i] : 8'hxx;
  endfunction
  function automatic logic [7:0] rd_at(input int i);
    return (rd_log.size() > i) ? rd_log[i] : 8'hxx;
  endfunction
  function automatic int span(input int first, input int last);
    return (rx_starts.size() > last) ? rx_starts[last] - rx_starts[first] : -1;
  endfunction

  task automatic settle(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic clear_stats();
    rx_log.delete();
    rd_log.delete();
    rx_starts.delete();
    done_seen = 0;
  endtask

  task automatic push_model(input logic [7:0] base, input int len);
    for (int w = 0; w < len; w++) begin
      logic [7:0] a;
      a = base + 8'(w);
      exp_addr.push_back(a);
      for (int b = 0; b < 4; b++) exp_byte.push_back(mem[a][8*b +: 8]);
    end
  endtask

  task automatic pulse_start(input logic [7:0] base, input int len);
    start_i = 1'b1;
    base_addr_i = base;
    len_i = 9'(len);
    @(posedge wb_clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit found = 0;
    int gaps = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge wb_clk_i);
      if (done_o) found = 1;
      else if (!busy_o) gaps++;
    end
    check({name, "_done_seen"}, found, 1'b1);
    check({name, "_busy_held"}, gaps, 0);
    settle(1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_model_drained"}, exp_addr.size() + exp_byte.size(), 0);
    check({name, "_one_done"}, done_seen, 1);
  endtask

  initial begin : watchdog
    #3_000_000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    int busy_hi;
    bit seen_low;
    #1 wb_rst_ni = 1'b0;
    #1;
    check("reset_tx", tx_o, 1'b1);
    check("reset_csb", csb1_o, 1'b1);
    check("reset_addr", addr1_o, 8'h00);
    check("reset_busy", busy_o, 1'b0);
    check("reset_done", done_o, 1'b0);

    // Single word; start raised together with reset release.
    @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    clear_stats();
    push_model(8'h10, 1);
    pulse_start(8'h10, 1);
    @(negedge wb_clk_i);
    check("s1_busy_first_edge", busy_o, 1'b1);
    wait_done("s1", 1000);
    settle(5);
    check("s1_reads", rd_log.size(), 1);
    check("s1_addr", rd_at(0), 8'h10);
    check("s1_bytes", rx_log.size(), 4);
    check("s1_byte0", rx_at(0), 8'h11);
    check("s1_byte3", rx_at(3), 8'h44);
    check("s1_span_120", span(0, 3), 120);
    check_drained("s1");

    // Address wrap 0xFF -> 0x00.
    clear_stats();
    push_model(8'hFF, 2);
    pulse_start(8'hFF, 2);
    wait_done("s2", 2000);
    settle(5);
    check("s2_reads", rd_log.size(), 2);
    check("s2_addr0", rd_at(0), 8'hFF);
    check("s2_addr1", rd_at(1), 8'h00);
    check("s2_bytes", rx_log.size(), 8);
    check_drained("s2");

    // Zero-length request.
    clear_stats();
    pulse_start(8'h33, 0);
    @(negedge wb_clk_i);
    check("s3_done_next", done_o, 1'b1);
    check("s3_busy_low", busy_o, 1'b0);
    @(negedge wb_clk_i);
    check("s3_done_one_cycle", done_o, 1'b0);
    busy_hi = 0;
    repeat (10) begin
      @(negedge wb_clk_i);
      if (busy_o) busy_hi++;
    end
    settle(1);
    check("s3_busy_never", busy_hi, 0);
    check("s3_no_reads", rd_log.size(), 0);
    check("s3_no_bytes", rx_log.size(), 0);
    check("s3_one_done", done_seen, 1);

    // Start during a transfer is dropped.
    clear_stats();
    push_model(8'h20, 3);
    pulse_start(8'h20, 3);
    settle(100);
    pulse_start(8'h40, 5);
    wait_done("s4", 3000);
    settle(200);
    check("s4_reads", rd_log.size(), 3);
    check("s4_bytes", rx_log.size(), 12);
    check_drained("s4");

    // Reset during a data bit, then a normal transfer.
    clear_stats();
    push_model(8'h30, 2);
    pulse_start(8'h30, 2);
    seen_low = 0;
    for (int i = 0; i < 500 && !seen_low; i++) begin
      @(negedge wb_clk_i);
      if (tx_o == 1'b0) seen_low = 1;
    end
    check("s5_frame_started", seen_low, 1'b1);
    repeat (6) @(negedge wb_clk_i);
    #2 wb_rst_ni = 1'b0;
    #1;
    check("s5_rst_tx", tx_o, 1'b1);
    check("s5_rst_busy", busy_o, 1'b0);
    check("s5_rst_csb", csb1_o, 1'b1);
    check("s5_rst_addr", addr1_o, 8'h00);
    exp_addr.delete();
    exp_byte.delete();
    settle(3);
    wb_rst_ni = 1'b1;
    settle(20);
    check("s5_no_done", done_seen, 0);
    check("s5_idle_busy", busy_o, 1'b0);
    clear_stats();
    push_model(8'h10, 1);
    pulse_start(8'h10, 1);
    wait_done("s5", 1000);
    settle(5);
    check("s5_bytes", rx_log.size(), 4);
    check("s5_byte0", rx_at(0), 8'h11);
    check("s5_byte2", rx_at(2), 8'h33);
    check_drained("s5");

    // Full 256-word transfer wrapping the address once.
    clear_stats();
    push_model(8'h80, 256);
    pulse_start(8'h80, 256);
    wait_done("s6", 50000);
    settle(5);
    check("s6_reads", rd_log.size(), 256);
    check("s6_wrap_addr", rd_at(128), 8'h00);
    check("s6_last_addr", rd_at(255), 8'h7F);
    check("s6_bytes", rx_log.size(), 1024);
    check_drained("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_uart_tx.md
SRAM_UART_TX -- requirements
Module: sram_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter RD_LAT, default 2: cycles from SRAM read-port select to dout1_i being valid (legal range 1..4).
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start_i, input, 1 bit: single-cycle request to begin a transfer.
REQ-006 SHALL have port base_addr_i, input, 8 bits: first SRAM word address, sampled with start_i.
REQ-007 SHALL have port len_i, input, 9 bits: number of 32-bit words to send (0..256), sampled with start_i.
REQ-008 SHALL have port busy_o, output, 1 bit: high from the accepted start through the final stop bit.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle pulse at transfer completion.
REQ-010 SHALL have port csb1_o, output, 1 bit: active-low chip select for the SRAM read-only port.
REQ-011 SHALL have port addr1_o, output, 8 bits: SRAM read-port word address.
REQ-012 SHALL have port dout1_i, input, 32 bits: SRAM read-port data.
REQ-013 SHALL have port tx_o, output, 1 bit: UART serial line, 8N1, idle high.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WAIT, SEND, NEXT.
REQ-015 IDLE: start_i=1 with len_i>0 SHALL latch the address and count, assert busy_o, and go to READ next cycle.
REQ-016 IDLE: start_i=1 with len_i=0 SHALL pulse done_o the following cycle, leave busy_o low and leave tx_o high.
REQ-017 start_i while busy_o=1 SHALL be ignored; no queuing.
REQ-018 READ: csb1_o SHALL be low for exactly one cycle with addr1_o = current address, then the FSM goes to WAIT.
REQ-019 WAIT: the FSM SHALL hold for RD_LAT cycles after the READ cycle, then capture dout1_i into a 32-bit shift register and go to SEND.
REQ-020 csb1_o SHALL be high in every state except READ.
REQ-021 SEND: the block SHALL transmit the 4 captured bytes least-significant byte first, each as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1).
REQ-022 Each UART bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-023 Consecutive bytes SHALL be transmitted back-to-back with no idle gap; one word therefore occupies 40*CLKS_PER_BIT cycles.
REQ-024 NEXT: the block SHALL increment the address modulo 256 (255 wraps to 0) and decrement the remaining count.
REQ-025 NEXT: if the remaining count is nonzero, the FSM SHALL go to READ.
REQ-026 NEXT: if the remaining count is zero, the FSM SHALL go to IDLE, pulse done_o for one cycle in the same cycle busy_o falls, and leave tx_o high.
REQ-027 Between words, tx_o SHALL remain high (idle) during the READ, WAIT and NEXT cycles.
REQ-028 len_i=256 SHALL send all 256 words, with the address wrapping once if base_addr_i>0.

Reset
REQ-029 Asserting wb_rst_ni low SHALL immediately force: FSM=IDLE, tx_o=1, csb1_o=1, addr1_o=0, busy_o=0, done_o=0, counters=0, shift register=0.
REQ-030 Reset asserted mid-frame SHALL abort the transfer and produce no done_o pulse; after release, the block SHALL wait for a new start_i.
REQ-031 The first start_i SHALL be accepted on the first rising edge after wb_rst_ni goes high.

Structure
REQ-032 The state enumeration, the SRAM address width (8), the data width (32) and the UART frame length (10) SHALL live in shared package sram_uart_pkg.
REQ-033 Byte serialization SHALL be a sub-module uart_tx_byte with a valid/ready handshake, parameter CLKS_PER_BIT, and ports for the byte, tx line and ready.
REQ-034 The top FSM SHALL sequence SRAM reads and hand bytes to uart_tx_byte; ready SHALL re-assert in the cycle after the stop bit ends.

Verification (CLKS_PER_BIT=4, RD_LAT=2)
REQ-035 Scenario: start, base=0x10, len=1, SRAM[0x10]=0x44332211 -> one csb1_o low pulse with addr1_o=0x10; tx_o carries bytes 0x11,0x22,0x33,0x44 over 160 cycles; one done_o pulse.
REQ-036 Scenario: start, base=0xFF, len=2 -> reads at addr1_o 0xFF then 0x00; 8 bytes sent; busy_o stays high throughout.
REQ-037 Scenario: start with len=0 -> done_o pulses one cycle later; busy_o never rises; tx_o and csb1_o stay high.
REQ-038 Scenario: second start_i asserted during a transfer with len=3 -> ignored; exactly 12 bytes sent and one done_o pulse.
REQ-039 Scenario: wb_rst_ni pulsed low mid data-bit -> tx_o=1 and busy_o=0 immediately, no done_o; a subsequent start with len=1 works normally.
REQ-040 Scenario: every bit is checked with a UART receiver model that samples mid-bit -> all 8N1 frames decode correctly and every stop bit =1.
